// File: rtl/vram_access_arbiter.sv
// Arbitrates the single-port VRAM between video fetch strobes and the host CPU port.
// Video normally wins; a saturating wait counter forces the CPU ahead after CPU_MAX_WAIT cycles.
module vram_access_arbiter #(
    parameter int unsigned ADDR_W       = 13,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CPU_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              vid_overrun
);

    localparam int unsigned WaitW = (CPU_MAX_WAIT > 0) ? $clog2(CPU_MAX_WAIT + 1) : 1;
    localparam logic [WaitW-1:0] WaitMax = WaitW'(CPU_MAX_WAIT);

    logic [WaitW-1:0]  cpu_wait_q, cpu_wait_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              own_vid_q, own_vid_d;
    logic              own_cpu_q, own_cpu_d;
    logic              vid_valid_q, vid_valid_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              cpu_rd_q, cpu_rd_d;
    logic [DATA_W-1:0] vid_data_q, vid_data_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              vid_overrun_q, vid_overrun_d;

    logic cpu_elig, force_cpu, gnt_cpu, gnt_pend, gnt_new;

    // Decision is made this cycle; the winner owns the RAM port next cycle.
    always_comb begin
        cpu_elig  = cpu_req & ~own_cpu_q & ~cpu_ack_q;
        force_cpu = cpu_elig & (cpu_wait_q == WaitMax);
        gnt_pend  = ~force_cpu & pend_valid_q;
        gnt_new   = ~force_cpu & ~pend_valid_q & vid_req;
        gnt_cpu   = force_cpu | (cpu_elig & ~pend_valid_q & ~vid_req);
    end

    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        if (gnt_pend) begin
            ram_addr_d = pend_addr_q;
        end else if (gnt_new) begin
            ram_addr_d = vid_addr;
        end else if (gnt_cpu) begin
            ram_addr_d = cpu_addr;
            ram_we_d   = cpu_we;
            if (cpu_we) begin
                ram_wdata_d = cpu_wdata;
            end
        end

        own_vid_d   = gnt_pend | gnt_new;
        own_cpu_d   = gnt_cpu;
        vid_valid_d = own_vid_q;
        cpu_ack_d   = own_cpu_q;
        cpu_rd_d    = own_cpu_q & ~ram_we_q;
        vid_data_d  = vid_valid_q ? ram_rdata : vid_data_q;
        cpu_rdata_d = cpu_rd_q ? ram_rdata : cpu_rdata_q;

        pend_valid_d  = pend_valid_q;
        pend_addr_d   = pend_addr_q;
        vid_overrun_d = vid_overrun_q;
        if (gnt_pend) begin
            pend_valid_d = vid_req;
            pend_addr_d  = vid_addr;
        end else if (vid_req && !gnt_new) begin
            // Only a forced CPU slot can displace a new strobe here.
            if (!pend_valid_q) begin
                pend_valid_d = 1'b1;
                pend_addr_d  = vid_addr;
            end else begin
                vid_overrun_d = 1'b1;
            end
        end

        cpu_wait_d = cpu_wait_q;
        if (!cpu_req || gnt_cpu) begin
            cpu_wait_d = '0;
        end else if (cpu_elig && (cpu_wait_q != WaitMax)) begin
            cpu_wait_d = cpu_wait_q + WaitW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_wait_q    <= '0;
            pend_valid_q  <= 1'b0;
            pend_addr_q   <= '0;
            ram_addr_q    <= '0;
            ram_we_q      <= 1'b0;
            ram_wdata_q   <= '0;
            own_vid_q     <= 1'b0;
            own_cpu_q     <= 1'b0;
            vid_valid_q   <= 1'b0;
            cpu_ack_q     <= 1'b0;
            cpu_rd_q      <= 1'b0;
            vid_data_q    <= '0;
            cpu_rdata_q   <= '0;
            vid_overrun_q <= 1'b0;
        end else begin
            cpu_wait_q    <= cpu_wait_d;
            pend_valid_q  <= pend_valid_d;
            pend_addr_q   <= pend_addr_d;
            ram_addr_q    <= ram_addr_d;
            ram_we_q      <= ram_we_d;
            ram_wdata_q   <= ram_wdata_d;
            own_vid_q     <= own_vid_d;
            own_cpu_q     <= own_cpu_d;
            vid_valid_q   <= vid_valid_d;
            cpu_ack_q     <= cpu_ack_d;
            cpu_rd_q      <= cpu_rd_d;
            vid_data_q    <= vid_data_d;
            cpu_rdata_q   <= cpu_rdata_d;
            vid_overrun_q <= vid_overrun_d;
        end
    end

    // Read data is forwarded straight from the RAM in the completion cycle, then held.
    assign vid_data    = vid_valid_q ? ram_rdata : vid_data_q;
    assign cpu_rdata   = cpu_rd_q ? ram_rdata : cpu_rdata_q;
    assign vid_valid   = vid_valid_q;
    assign cpu_ack     = cpu_ack_q;
    assign ram_addr    = ram_addr_q;
    assign ram_we      = ram_we_q;
    assign ram_wdata   = ram_wdata_q;
    assign vid_overrun = vid_overrun_q;

endmodule

// File: tb/tb_vram_access_arbiter.sv
// Directed bench for vram_access_arbiter with a behavioural one-cycle-latency VRAM.
module tb_vram_access_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        vid_req;
    logic [12:0] vid_addr;
    logic [7:0]  vid_data;
    logic        vid_valid;
    logic        cpu_req;
    logic        cpu_we;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic [12:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        vid_overrun;

    int checks = 0;
    int errors = 0;

    bit [7:0] mem [8192];
    bit       wr  [8192];

    vram_access_arbiter #(
        .ADDR_W(13),
        .DATA_W(8),
        .CPU_MAX_WAIT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .vid_req(vid_req),
        .vid_addr(vid_addr),
        .vid_data(vid_data),
        .vid_valid(vid_valid),
        .cpu_req(cpu_req),
        .cpu_we(cpu_we),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_ack(cpu_ack),
        .ram_addr(ram_addr),
        .ram_we(ram_we),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .vid_overrun(vid_overrun)
    );

    always #5 clk = ~clk;

    // Initial RAM contents: 0xA5 at 0x0100, a fixed pattern elsewhere.
    function automatic logic [7:0] pat(input logic [12:0] a);
        return (a == 13'h0100) ? 8'hA5 : (a[7:0] ^ 8'h5A);
    endfunction

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            wr[ram_addr]  <= 1'b1;
        end
        ram_rdata <= wr[ram_addr] ? mem[ram_addr] : pat(ram_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        vid_req = 1'b0;
        cpu_req = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(2);
        checks++;
        if ({ram_addr, ram_we, ram_wdata, vid_valid, vid_data, cpu_ack, cpu_rdata, vid_overrun}
            !== '0) begin
            errors++;
            $display("FAIL reset_outputs got addr=%h we=%b wd=%h vv=%b vd=%h ack=%b rd=%h ov=%b want all 0",
                     ram_addr, ram_we, ram_wdata, vid_valid, vid_data, cpu_ack, cpu_rdata,
                     vid_overrun);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_cpu_read();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0100;
        tick();
        checks++;
        if (ram_addr !== 13'h0100 || ram_we !== 1'b0 || cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL rd_grant got addr=%h we=%b ack=%b want 0100 0 0", ram_addr, ram_we, cpu_ack);
        end
        tick();
        checks++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hA5) begin
            errors++;
            $display("FAIL rd_ack got ack=%b rdata=%h want 1 a5", cpu_ack, cpu_rdata);
        end
        tick();
        checks++;
        if (cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL rd_no_regrant_c3 got ack=%b want 0", cpu_ack);
        end
        cpu_req = 1'b0;
        tick();
        checks++;
        if (cpu_ack !== 1'b0 || cpu_rdata !== 8'hA5) begin
            errors++;
            $display("FAIL rd_no_regrant_c4 got ack=%b rdata=%h want 0 a5", cpu_ack, cpu_rdata);
        end
        idle(2);
    endtask

    task automatic test_cpu_write();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h1FFF; cpu_wdata = 8'h3C;
        tick();
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== 13'h1FFF || ram_wdata !== 8'h3C) begin
            errors++;
            $display("FAIL wr_grant got we=%b addr=%h wd=%h want 1 1fff 3c", ram_we, ram_addr, ram_wdata);
        end
        tick();
        checks++;
        if (ram_we !== 1'b0 || cpu_ack !== 1'b1 || cpu_rdata !== 8'hA5) begin
            errors++;
            $display("FAIL wr_ack got we=%b ack=%b rdata=%h want 0 1 a5", ram_we, cpu_ack, cpu_rdata);
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
        vid_req = 1'b1; vid_addr = 13'h1FFF;
        tick();
        vid_req = 1'b0;
        checks++;
        if (ram_addr !== 13'h1FFF || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL wr_vid_grant got addr=%h we=%b want 1fff 0", ram_addr, ram_we);
        end
        tick();
        checks++;
        if (vid_valid !== 1'b1 || vid_data !== 8'h3C) begin
            errors++;
            $display("FAIL wr_vid_readback got vv=%b vd=%h want 1 3c", vid_valid, vid_data);
        end
        tick();
        checks++;
        if (vid_valid !== 1'b0 || vid_data !== 8'h3C) begin
            errors++;
            $display("FAIL wr_vid_hold got vv=%b vd=%h want 0 3c", vid_valid, vid_data);
        end
        idle(2);
    endtask

    // Continuous strobes with the CPU waiting: forced slot at the 5th waiting cycle.
    task automatic test_forced();
        logic       exp_v;
        logic [7:0] exp_d;
        int         t;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0100;
        for (int c = 0; c < 14; c++) begin
            vid_req  = (c < 10);
            vid_addr = 13'(c);
            tick();
            t = c + 1;
            exp_v = (t >= 2 && t <= 5) || (t >= 7 && t <= 12);
            exp_d = pat(13'((t <= 5) ? t - 2 : t - 3));
            checks++;
            if (vid_valid !== exp_v || (exp_v && vid_data !== exp_d)) begin
                errors++;
                $display("FAIL forced_vid t=%0d got vv=%b vd=%h want %b %h", t, vid_valid, vid_data,
                         exp_v, exp_d);
            end
            checks++;
            if (cpu_ack !== (t == 6) || (t == 6 && cpu_rdata !== 8'hA5)) begin
                errors++;
                $display("FAIL forced_ack t=%0d got ack=%b rd=%h want %b a5", t, cpu_ack, cpu_rdata,
                         (t == 6));
            end
            if (t == 5) begin
                checks++;
                if (ram_addr !== 13'h0100) begin
                    errors++;
                    $display("FAIL forced_grant got addr=%h want 0100", ram_addr);
                end
            end
            if (cpu_ack) cpu_req = 1'b0;
        end
        checks++;
        if (vid_overrun !== 1'b0) begin
            errors++;
            $display("FAIL forced_no_overrun got %b want 0", vid_overrun);
        end
        idle(3);
    endtask

    // Sparse strobes every 8 cycles with CPU reads slotted in between.
    task automatic test_strobe_interleave();
        logic exp_v, exp_a;
        int   t;
        cpu_we = 1'b0;
        for (int c = 0; c < 40; c++) begin
            vid_req  = (c % 8 == 0);
            vid_addr = 13'h0040 + 13'(c / 8);
            if (c % 8 == 3) begin
                cpu_req  = 1'b1;
                cpu_addr = 13'h0050 + 13'(c / 8);
            end
            tick();
            t = c + 1;
            exp_v = (t >= 2) && ((t - 2) % 8 == 0);
            exp_a = (t >= 5) && ((t - 5) % 8 == 0);
            checks++;
            if (vid_valid !== exp_v || (exp_v && vid_data !== pat(13'h0040 + 13'((t - 2) / 8)))) begin
                errors++;
                $display("FAIL strobe_vid t=%0d got vv=%b vd=%h want %b", t, vid_valid, vid_data, exp_v);
            end
            checks++;
            if (cpu_ack !== exp_a || (exp_a && cpu_rdata !== pat(13'h0050 + 13'((t - 5) / 8)))) begin
                errors++;
                $display("FAIL strobe_cpu t=%0d got ack=%b rd=%h want %b", t, cpu_ack, cpu_rdata, exp_a);
            end
            if (cpu_ack) cpu_req = 1'b0;
        end
        idle(3);
    endtask

    // Keep CPU requesting so a second forced slot lands on a full pending buffer.
    task automatic test_overrun();
        logic [12:0] exp_list [13];
        int          n = 0;
        int          acks = 0;
        int          t;
        for (int i = 0; i < 10; i++) exp_list[i] = 13'h0020 + 13'(i);
        exp_list[10] = 13'h002A;
        exp_list[11] = 13'h002C;
        exp_list[12] = 13'h002D;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0100;
        for (int c = 0; c < 20; c++) begin
            vid_req  = (c <= 13);
            vid_addr = 13'h0020 + 13'(c);
            tick();
            t = c + 1;
            checks++;
            if (vid_overrun !== (t >= 12)) begin
                errors++;
                $display("FAIL overrun_flag t=%0d got %b want %b", t, vid_overrun, (t >= 12));
            end
            if (vid_valid) begin
                checks++;
                if (n >= 13) begin
                    errors++;
                    $display("FAIL overrun_extra_valid t=%0d got vd=%h want none", t, vid_data);
                end else if (vid_data !== pat(exp_list[n])) begin
                    errors++;
                    $display("FAIL overrun_order n=%0d got %h want %h", n, vid_data, pat(exp_list[n]));
                end
                n++;
            end
            if (cpu_ack) begin
                acks++;
                if (acks == 2) cpu_req = 1'b0;
            end
        end
        checks++;
        if (n !== 13 || acks !== 2) begin
            errors++;
            $display("FAIL overrun_counts got valids=%0d acks=%0d want 13 2", n, acks);
        end
        idle(3);
        checks++;
        if (vid_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky got %b want 1", vid_overrun);
        end
    endtask

    task automatic test_reset_midflight();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0100;
        tick();
        checks++;
        if (ram_addr !== 13'h0100) begin
            errors++;
            $display("FAIL mid_grant got addr=%h want 0100", ram_addr);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({ram_addr, ram_we, ram_wdata, vid_valid, vid_data, cpu_ack, cpu_rdata, vid_overrun}
            !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got addr=%h we=%b ack=%b rd=%h vd=%h ov=%b want all 0",
                     ram_addr, ram_we, cpu_ack, cpu_rdata, vid_data, vid_overrun);
        end
        tick();
        checks++;
        if (cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_noack got %b want 0", cpu_ack);
        end
        reset = 1'b0; vid_req = 1'b1; vid_addr = 13'h0033;
        tick();
        vid_req = 1'b0;
        checks++;
        if (ram_addr !== 13'h0033 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_vid_first got addr=%h we=%b want 0033 0", ram_addr, ram_we);
        end
        tick();
        checks++;
        if (vid_valid !== 1'b1 || vid_data !== 8'h69 || ram_addr !== 13'h0100) begin
            errors++;
            $display("FAIL post_reset_cpu_grant got vv=%b vd=%h addr=%h want 1 69 0100",
                     vid_valid, vid_data, ram_addr);
        end
        tick();
        checks++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hA5) begin
            errors++;
            $display("FAIL post_reset_cpu_ack got ack=%b rd=%h want 1 a5", cpu_ack, cpu_rdata);
        end
        idle(2);
    endtask

    initial begin
        reset     = 1'b1;
        vid_req   = 1'b0;
        vid_addr  = '0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_forced();
        test_strobe_interleave();
        test_overrun();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
